// File: rtl/s38417_pkg.sv
// Shared constants and types for the s38417 pattern loader: word width,
// bank count, write-port address map and the scan sequencer state encoding.
package s38417_pkg;

    localparam int W     = 9;
    localparam int NBANK = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_B0  = 2'd0;
    localparam logic [1:0] ADDR_B1  = 2'd1;
    localparam logic [1:0] ADDR_B2  = 2'd2;
    localparam logic [1:0] ADDR_REF = 2'd3;

    // Scan index to one-hot checker select; out-of-range indices give no select.
    function automatic logic [NBANK-1:0] idx_to_sel(input logic [1:0] idx);
        logic [NBANK-1:0] sel_v;
        case (idx)
            2'd0:    sel_v = 3'b001;
            2'd1:    sel_v = 3'b010;
            2'd2:    sel_v = 3'b100;
            default: sel_v = 3'b000;
        endcase
        return sel_v;
    endfunction

endpackage

// File: rtl/s38417_bank_regfile.sv
// Three pattern banks plus the reference word, with a per-entry valid bit.
// Writes set the entry's valid bit; a scan completion clears all valid bits.
module s38417_bank_regfile
    import s38417_pkg::*;
(
    input  logic         CK,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic [1:0]   i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_clr_vld,
    output logic [W-1:0] o_bank0,
    output logic [W-1:0] o_bank1,
    output logic [W-1:0] o_bank2,
    output logic [W-1:0] o_ref,
    output logic [3:0]   o_vld
);

    logic [W-1:0] r_bank0;
    logic [W-1:0] r_bank1;
    logic [W-1:0] r_bank2;
    logic [W-1:0] r_ref;
    logic [3:0]   r_vld;
    logic [3:0]   w_wr_onehot;

    // Decode the write address into the valid bit it sets.
    always_comb begin
        w_wr_onehot = 4'b0000;
        case (i_waddr)
            ADDR_B0:  w_wr_onehot = 4'b0001;
            ADDR_B1:  w_wr_onehot = 4'b0010;
            ADDR_B2:  w_wr_onehot = 4'b0100;
            ADDR_REF: w_wr_onehot = 4'b1000;
            default:  w_wr_onehot = 4'b0000;
        endcase
    end

    // Data storage: the addressed word is overwritten on every accepted write.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_bank0 <= {W{1'b0}};
            r_bank1 <= {W{1'b0}};
            r_bank2 <= {W{1'b0}};
            r_ref   <= {W{1'b0}};
        end else if (i_we) begin
            case (i_waddr)
                ADDR_B0:  r_bank0 <= i_wdata;
                ADDR_B1:  r_bank1 <= i_wdata;
                ADDR_B2:  r_bank2 <= i_wdata;
                ADDR_REF: r_ref   <= i_wdata;
                default:  r_ref   <= r_ref;
            endcase
        end else begin
            r_bank0 <= r_bank0;
        end
    end

    // Valid tracking; clear and write never coincide since writes stall outside IDLE.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 4'b0000;
        end else if (i_clr_vld) begin
            r_vld <= 4'b0000;
        end else if (i_we) begin
            r_vld <= r_vld | w_wr_onehot;
        end else begin
            r_vld <= r_vld;
        end
    end

    assign o_bank0 = r_bank0;
    assign o_bank1 = r_bank1;
    assign o_bank2 = r_bank2;
    assign o_ref   = r_ref;
    assign o_vld   = r_vld;

endmodule

// File: rtl/s38417_pattern_loader.sv
// Loads pattern banks and a reference word, then walks a one-hot select across
// the banks while collecting the checker's match flag into match_vec.
module s38417_pattern_loader
    import s38417_pkg::*;
(
    input  logic             CK,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             start,
    output logic [NBANK-1:0] sel,
    output logic [W-1:0]     bank0_q,
    output logic [W-1:0]     bank1_q,
    output logic [W-1:0]     bank2_q,
    output logic [W-1:0]     ref_q,
    output logic             upd,
    input  logic             match_in,
    output logic [NBANK-1:0] match_vec,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [NBANK-1:0] r_sel;
    logic [NBANK-1:0] w_sel_nxt;
    logic             r_upd;
    logic             w_upd_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [NBANK-1:0] r_match_vec;
    logic [NBANK-1:0] w_match_vec_nxt;
    logic             w_clr_vld;
    logic             w_wr_fire;
    logic [3:0]       w_vld;
    logic             w_vld_all;

    assign wr_ready  = (r_state == IDLE);
    assign w_wr_fire = wr_valid & wr_ready;
    // Registered valid bits hold the pre-write view for a same-cycle start.
    assign w_vld_all = (w_vld == 4'b1111);

    s38417_bank_regfile u_regfile (
        .CK        (CK),
        .rst_n     (rst_n),
        .i_we      (w_wr_fire),
        .i_waddr   (wr_addr),
        .i_wdata   (wr_data),
        .i_clr_vld (w_clr_vld),
        .o_bank0   (bank0_q),
        .o_bank1   (bank1_q),
        .o_bank2   (bank2_q),
        .o_ref     (ref_q),
        .o_vld     (w_vld)
    );

    // Next-state and next-output decode for the scan sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_sel_nxt       = 3'b000;
        w_upd_nxt       = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_match_vec_nxt = r_match_vec;
        w_clr_vld       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_vld_all) begin
                        w_state_nxt     = SCAN;
                        w_idx_nxt       = 2'd0;
                        w_sel_nxt       = idx_to_sel(2'd0);
                        w_upd_nxt       = 1'b1;
                        w_busy_nxt      = 1'b1;
                        w_match_vec_nxt = 3'b000;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                // match_vec was cleared on entry, so OR-ing in the current lane suffices.
                w_match_vec_nxt = r_match_vec | (idx_to_sel(r_idx) & {NBANK{match_in}});
                if (r_idx == 2'd2) begin
                    w_state_nxt = DONE;
                    w_idx_nxt   = 2'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt  = r_idx + 2'd1;
                    w_sel_nxt  = idx_to_sel(r_idx + 2'd1);
                    w_upd_nxt  = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_clr_vld   = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // State and scan index registers.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Registered outputs toward the checker and the configuration master.
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= 3'b000;
            r_upd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_match_vec <= 3'b000;
        end else begin
            r_sel       <= w_sel_nxt;
            r_upd       <= w_upd_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_match_vec <= w_match_vec_nxt;
        end
    end

    assign sel       = r_sel;
    assign upd       = r_upd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign match_vec = r_match_vec;

endmodule

// File: tb/tb_s38417_pattern_loader.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized phase, all checked against a bank/valid/match reference model.
module tb_s38417_pattern_loader;

    logic       CK;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [8:0] wr_data;
    logic       start;
    logic [2:0] sel;
    logic [8:0] bank0_q;
    logic [8:0] bank1_q;
    logic [8:0] bank2_q;
    logic [8:0] ref_q;
    logic       upd;
    logic       match_in;
    logic [2:0] match_vec;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model
    logic [8:0] m_bank [4];
    logic [3:0] m_vld;
    logic [2:0] m_mv;

    s38417_pattern_loader dut (
        .CK        (CK),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .sel       (sel),
        .bank0_q   (bank0_q),
        .bank1_q   (bank1_q),
        .bank2_q   (bank2_q),
        .ref_q     (ref_q),
        .upd       (upd),
        .match_in  (match_in),
        .match_vec (match_vec),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // checker cone: selected bank equals reference
    always_comb begin
        case (sel)
            3'b001:  match_in = (bank0_q == ref_q);
            3'b010:  match_in = (bank1_q == ref_q);
            3'b100:  match_in = (bank2_q == ref_q);
            default: match_in = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_bank[i] = 9'h000;
        m_vld = 4'b0000;
        m_mv  = 3'b000;
    endtask

    // One operation cycle (write and/or start), then verify the whole outcome.
    task automatic step_op(input logic wr, input logic [1:0] a, input logic [8:0] d, input logic st);
        logic       acc;
        logic       rej;
        logic [2:0] exp_mv;
        acc = st && (m_vld == 4'b1111);
        rej = st && !acc;
        wr_valid = wr;
        wr_addr  = a;
        wr_data  = d;
        start    = st;
        cyc();
        wr_valid = 1'b0;
        start    = 1'b0;
        if (wr) begin
            m_bank[a] = d;
            m_vld[a]  = 1'b1;
        end
        chk("err", err, rej);
        chk("bank0_q", bank0_q, m_bank[0]);
        chk("bank1_q", bank1_q, m_bank[1]);
        chk("bank2_q", bank2_q, m_bank[2]);
        chk("ref_q", ref_q, m_bank[3]);
        if (acc) begin
            for (int i = 0; i < 3; i++) begin
                exp_mv[i] = (m_bank[i] == m_bank[3]);
            end
            for (int i = 0; i < 3; i++) begin
                chk("scan_sel", sel, 3'b001 << i);
                chk("scan_upd", upd, 1'b1);
                chk("scan_busy", busy, 1'b1);
                chk("scan_wr_ready", wr_ready, 1'b0);
                chk("scan_done", done, 1'b0);
                cyc();
            end
            chk("done_pulse", done, 1'b1);
            chk("done_sel", sel, 3'b000);
            chk("done_upd", upd, 1'b0);
            chk("done_busy", busy, 1'b0);
            chk("match_vec", match_vec, exp_mv);
            m_mv  = exp_mv;
            m_vld = 4'b0000;
            cyc();
            chk("done_drop", done, 1'b0);
            chk("idle_wr_ready", wr_ready, 1'b1);
            chk("idle_mv", match_vec, m_mv);
        end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_sel", sel, 3'b000);
            chk("idle_upd", upd, 1'b0);
            chk("idle_mv", match_vec, m_mv);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [8:0] data;
        logic       st;
        logic       exp_err;
        logic [2:0] exp_mv;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [8:0] held;
        logic [1:0] ra;
        logic [8:0] rd;
        int         r;

        tbl[0]  = '{1'b1, 2'd0, 9'h1A5, 1'b0, 1'b0, 3'b000};
        tbl[1]  = '{1'b1, 2'd1, 9'h0F0, 1'b0, 1'b0, 3'b000};
        tbl[2]  = '{1'b1, 2'd2, 9'h155, 1'b0, 1'b0, 3'b000};
        tbl[3]  = '{1'b1, 2'd3, 9'h1A5, 1'b0, 1'b0, 3'b000};
        tbl[4]  = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b0, 3'b001};
        tbl[5]  = '{1'b1, 2'd0, 9'h0F0, 1'b0, 1'b0, 3'b001};
        tbl[6]  = '{1'b1, 2'd1, 9'h0F0, 1'b0, 1'b0, 3'b001};
        tbl[7]  = '{1'b1, 2'd3, 9'h0F0, 1'b0, 1'b0, 3'b001};
        tbl[8]  = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 3'b001};
        tbl[9]  = '{1'b1, 2'd2, 9'h0F0, 1'b1, 1'b1, 3'b001};
        tbl[10] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b0, 3'b111};
        tbl[11] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 3'b111};
        tbl[12] = '{1'b1, 2'd3, 9'h0F0, 1'b0, 1'b0, 3'b111};
        tbl[13] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b1, 3'b111};
        tbl[14] = '{1'b1, 2'd0, 9'h1A5, 1'b0, 1'b0, 3'b111};
        tbl[15] = '{1'b1, 2'd1, 9'h0F0, 1'b0, 1'b0, 3'b111};
        tbl[16] = '{1'b1, 2'd2, 9'h155, 1'b0, 1'b0, 3'b111};
        tbl[17] = '{1'b1, 2'd3, 9'h0F0, 1'b0, 1'b0, 3'b111};
        tbl[18] = '{1'b0, 2'd0, 9'h000, 1'b1, 1'b0, 3'b010};

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 9'h000;
        start    = 1'b0;
        model_reset();
        #3;
        chk("rst_sel", sel, 3'b000);
        chk("rst_upd", upd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_mv", match_vec, 3'b000);
        chk("rst_bank0", bank0_q, 9'h000);
        @(negedge CK);
        rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            step_op(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].st);
            chk("tbl_mv", match_vec, tbl[i].exp_mv);
            if (!tbl[i].st) chk("tbl_err", err, tbl[i].exp_err);
            else if (tbl[i].exp_err) chk("tbl_err", err, tbl[i].exp_err);
        end

        // write held during a scan lands on the first IDLE cycle
        step_op(1'b1, 2'd0, 9'h011, 1'b0);
        step_op(1'b1, 2'd1, 9'h022, 1'b0);
        step_op(1'b1, 2'd2, 9'h011, 1'b0);
        step_op(1'b1, 2'd3, 9'h011, 1'b0);
        held  = 9'h003;
        start = 1'b1;
        cyc();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = held;
        for (int i = 0; i < 4; i++) begin
            chk("held_wr_ready", wr_ready, 1'b0);
            chk("held_bank0", bank0_q, 9'h011);
            cyc();
        end
        chk("held_idle_ready", wr_ready, 1'b1);
        chk("held_idle_bank0", bank0_q, 9'h011);
        chk("held_mv", match_vec, 3'b101);
        cyc();
        wr_valid = 1'b0;
        chk("held_landed", bank0_q, held);
        m_bank[0] = held;
        m_vld     = 4'b0001;
        m_mv      = 3'b101;

        // asynchronous reset in the middle of a scan
        step_op(1'b1, 2'd1, 9'h0AA, 1'b0);
        step_op(1'b1, 2'd2, 9'h0AA, 1'b0);
        step_op(1'b1, 2'd3, 9'h0AA, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("pre_rst_sel", sel, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel, 3'b000);
        chk("mid_rst_upd", upd, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mv", match_vec, 3'b000);
        chk("mid_rst_bank1", bank1_q, 9'h000);
        chk("mid_rst_ref", ref_q, 9'h000);
        chk("mid_rst_done", done, 1'b0);
        model_reset();
        @(negedge CK);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_ready", wr_ready, 1'b1);
        step_op(1'b0, 2'd0, 9'h000, 1'b1);

        // randomized phase against the model
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 9);
            ra = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rd = 9'h1A5;
                1:       rd = 9'h0F0;
                2:       rd = m_bank[3];
                default: rd = 9'($urandom());
            endcase
            step_op((r < 7) || (r == 9), ra, rd, (r >= 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
